// File: rtl/s_machine_pkg.sv
// s_machine_pkg: opcodes, stage states and flag bit positions shared by the S-Machine datapath.
package s_machine_pkg;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
endpackage

// File: rtl/wb_decode.sv
// wb_decode: maps the opcode field (and INC's target bit) to per-register write enables.
module wb_decode
    import s_machine_pkg::*;
(
    input  logic [15:11] i_ir,
    output logic         o_we_a,
    output logic         o_we_b,
    output logic         o_we_flags
);
    logic [3:0] w_op;
    logic       w_arith;

    assign w_op       = i_ir[15:12];
    assign w_arith    = (w_op >= OP_ADD) && (w_op <= OP_SHR);
    assign o_we_a     = (w_op == OP_INC && !i_ir[11]) || w_arith || w_op == OP_EXCH;
    assign o_we_b     = (w_op == OP_INC && i_ir[11]) || w_op == OP_MOV || w_op == OP_EXCH;
    assign o_we_flags = w_op == OP_INC || w_arith || w_op == OP_CMP || w_op == OP_SET || w_op == OP_CLR;
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: owns A/B/flags, holds an instruction on the ALU for a settle interval,
// then writes back the enabled results; also accepts direct register loads while idle.
module alu_exec_stage
    import s_machine_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_sel,
    input  logic [15:0] ld_data,
    output logic [15:0] alu_inst,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_z,
    output logic        alu_n,
    output logic        alu_c,
    input  logic [15:0] res_a,
    input  logic [15:0] res_b,
    input  logic        res_z,
    input  logic        res_n,
    input  logic        res_c,
    output logic [15:0] reg_a,
    output logic [15:0] reg_b,
    output logic [2:0]  flags,
    output logic        busy,
    output logic        done
);
    state_t      r_state, w_next;
    logic [15:0] r_ir, r_a, r_b;
    logic [2:0]  r_flags;
    logic [3:0]  r_cnt;
    logic        w_idle, w_wb, w_we_a, w_we_b, w_we_flags;

    wb_decode u_wb_decode (
        .i_ir      (r_ir[15:11]),
        .o_we_a    (w_we_a),
        .o_we_b    (w_we_b),
        .o_we_flags(w_we_flags)
    );

    assign w_idle = r_state == ST_IDLE;
    assign w_wb   = r_state == ST_WB;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;

    always_comb
        w_next = w_idle              ? (inst_valid ? ST_EXEC : ST_IDLE) :
                 r_state == ST_EXEC  ? (r_cnt == '0 ? ST_WB : ST_EXEC) :
                                       ST_IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ir    <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_flags <= '0;
        end else begin
            if (w_idle && inst_valid) begin
                r_ir  <= inst;
                r_cnt <= 4'(SETTLE_CYCLES - 1);
            end else if (r_state == ST_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // loads and writeback live in disjoint states, so they never collide
            if (w_idle && ld_valid && !ld_sel) r_a <= ld_data;
            else if (w_wb && w_we_a)           r_a <= res_a;
            if (w_idle && ld_valid && ld_sel)  r_b <= ld_data;
            else if (w_wb && w_we_b)           r_b <= res_b;
            if (w_wb && w_we_flags)            r_flags <= {res_z, res_n, res_c};
        end

    assign inst_ready = w_idle;
    assign ld_ready   = w_idle;
    assign busy       = !w_idle;
    assign done       = w_wb;
    assign alu_inst   = w_idle ? 16'h0000 : r_ir;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_z      = r_flags[FLAG_Z];
    assign alu_n      = r_flags[FLAG_N];
    assign alu_c      = r_flags[FLAG_C];
    assign reg_a      = r_a;
    assign reg_b      = r_b;
    assign flags      = r_flags;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors with hand-computed results for SETTLE_CYCLES = 1 and 4.
module tb_alu_exec_stage;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic        inst_valid = 0, ld_valid = 0, ld_sel = 0;
    logic [15:0] inst = 0, ld_data = 0, res_a = 0, res_b = 0;
    logic        res_z = 0, res_n = 0, res_c = 0;
    logic        inst_ready, ld_ready, alu_z, alu_n, alu_c, busy, done;
    logic [15:0] alu_inst, alu_a, alu_b, reg_a, reg_b;
    logic [2:0]  flags;

    logic        inst_valid4 = 0, ld_valid4 = 0, ld_sel4 = 0;
    logic [15:0] inst4 = 0, ld_data4 = 0, res_a4 = 0, res_b4 = 0;
    logic        res_z4 = 0, res_n4 = 0, res_c4 = 0;
    logic        inst_ready4, ld_ready4, alu_z4, alu_n4, alu_c4, busy4, done4;
    logic [15:0] alu_inst4, alu_a4, alu_b4, reg_a4, reg_b4;
    logic [2:0]  flags4;

    int n_chk = 0, n_err = 0;

    alu_exec_stage #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .res_a(res_a), .res_b(res_b), .res_z(res_z), .res_n(res_n), .res_c(res_c),
        .reg_a(reg_a), .reg_b(reg_b), .flags(flags), .busy(busy), .done(done)
    );

    alu_exec_stage #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid4), .inst_ready(inst_ready4), .inst(inst4),
        .ld_valid(ld_valid4), .ld_ready(ld_ready4), .ld_sel(ld_sel4), .ld_data(ld_data4),
        .alu_inst(alu_inst4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_z(alu_z4), .alu_n(alu_n4), .alu_c(alu_c4),
        .res_a(res_a4), .res_b(res_b4), .res_z(res_z4), .res_n(res_n4), .res_c(res_c4),
        .reg_a(reg_a4), .reg_b(reg_b4), .flags(flags4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [15:0] d);
        ld_valid = 1; ld_sel = sel; ld_data = d;
        tick;
        ld_valid = 0;
    endtask

    // Issues one instruction on the SETTLE_CYCLES=1 stage and walks it to the first IDLE cycle after WB.
    task automatic run_inst(input string tag, input logic [15:0] ins);
        chk({tag, "_idle_inst"}, alu_inst, 16'h0000);
        chk({tag, "_ready"}, inst_ready, 1);
        inst = ins; inst_valid = 1;
        tick;
        inst_valid = 0;
        chk({tag, "_exec_inst"}, alu_inst, ins);
        chk({tag, "_exec_done"}, done, 0);
        tick;
        chk({tag, "_wb_done"}, done, 1);
        tick;
        chk({tag, "_post_done"}, done, 0);
    endtask

    initial begin
        #3;
        chk("rst_a", reg_a, 0);
        chk("rst_b", reg_b, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_inst", alu_inst, 0);
        @(negedge clk) rst_n = 1;
        tick;

        load(0, 16'h0005);
        load(1, 16'h0003);
        chk("ld_a", reg_a, 16'h0005);
        chk("ld_b", reg_b, 16'h0003);
        chk("alu_a", alu_a, 16'h0005);

        res_a = 16'h0008; res_b = 16'h1234; {res_z, res_n, res_c} = 3'b001;
        run_inst("add", 16'h4000);
        chk("add_a", reg_a, 16'h0008);
        chk("add_b", reg_b, 16'h0003);
        chk("add_flags", flags, 3'b001);
        chk("add_busy", busy, 0);

        res_a = 16'hDEAD; res_b = 16'h0004; {res_z, res_n, res_c} = 3'b000;
        run_inst("incb", 16'h2801);
        chk("incb_a", reg_a, 16'h0008);
        chk("incb_b", reg_b, 16'h0004);
        chk("incb_flags", flags, 3'b000);

        load(0, 16'h0007);
        load(1, 16'h0007);
        res_a = 16'h1111; res_b = 16'h2222; {res_z, res_n, res_c} = 3'b100;
        run_inst("cmp1", 16'hC000);
        chk("cmp_flags", flags, 3'b100);
        chk("cmp_a", reg_a, 16'h0007);
        chk("cmp_b", reg_b, 16'h0007);
        chk("cmp_alu_z", alu_z, 1);
        run_inst("cmp2", 16'hC000);

        // load A and MOV handshake on the same edge; MOV copies the post-load A into B
        res_a = 16'h0BAD; res_b = 16'hFFFF; {res_z, res_n, res_c} = 3'b011;
        ld_valid = 1; ld_sel = 0; ld_data = 16'hFFFF;
        inst = 16'hA000; inst_valid = 1;
        tick;
        inst_valid = 0;
        chk("mov_postload_a", alu_a, 16'hFFFF);
        ld_data = 16'h5555;
        chk("mov_ld_ready", ld_ready, 0);
        tick;
        chk("mov_wb_done", done, 1);
        chk("mov_blocked_ld", reg_a, 16'hFFFF);
        tick;
        ld_valid = 0;
        chk("mov_b", reg_b, 16'hFFFF);
        chk("mov_a", reg_a, 16'hFFFF);
        chk("mov_flags", flags, 3'b100);

        res_a4 = 16'h0077;
        inst4 = 16'h4000; inst_valid4 = 1;
        tick;
        inst4 = 16'hE000;
        begin
            int n = 1;
            while (!done4 && n < 20) begin
                chk("s4_busy", busy4, 1);
                chk("s4_hold_inst", alu_inst4, 16'h4000);
                tick;
                n++;
            end
            chk("s4_latency", n, 5);
        end
        chk("s4_wb_inst", alu_inst4, 16'h4000);
        inst_valid4 = 0;
        tick;
        chk("s4_a", reg_a4, 16'h0077);
        chk("s4_idle_inst", alu_inst4, 0);

        res_a = 16'h0001;
        inst = 16'h5000; inst_valid = 1;
        tick;
        inst_valid = 0;
        chk("sub_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_a", reg_a, 0);
        chk("arst_b", reg_b, 0);
        chk("arst_flags", flags, 0);
        chk("arst_busy", busy, 0);
        chk("arst_inst", alu_inst, 0);
        chk("arst_ready", inst_ready, 1);
        @(negedge clk) rst_n = 1;
        tick;
        tick;
        chk("arst_no_wb", reg_a, 0);
        chk("arst_done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
